// File: rtl/line_char_arbiter.sv
// ---------------------------------------------------------------------------
// line_char_arbiter
//
// Purpose:
//   Shares the single character stream into vga_display between two
//   byte-producing sources. A grant covers one whole line, so text from the
//   two sources never interleaves within a display row. The block also paces
//   emissions, forces a newline at the display width, and takes the grant
//   back from a source that stops sending for too long.
//
// Parameters:
//   PACE     - minimum clocks between consecutive data_valid strobes (>= 1)
//   LINE_MAX - maximum non-newline characters per line, tag bytes included
//   TIMEOUT  - cycles the granted source may hold valid low before its line
//              is terminated with a forced newline (>= 2)
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   s0_data    - source 0 byte
//   s0_valid   - source 0 byte available
//   s0_ready   - source 0 byte accepted this cycle when s0_valid is high
//   s1_data    - source 1 byte
//   s1_valid   - source 1 byte available
//   s1_ready   - source 1 byte accepted this cycle when s1_valid is high
//   char_data  - registered byte to display (holds between strobes)
//   data_valid - registered one-cycle strobe qualifying char_data
//   grant_src  - index of the currently or most recently granted source
//   busy       - high whenever the arbiter is not idle
//
// Build option:
//   LINE_TAG_EN - when defined, each line is prefixed with "0:" or "1:"
//                 naming its source; the two tag bytes count toward
//                 LINE_MAX. When undefined, a grant goes straight to
//                 passing source bytes and no prefix is emitted.
// ---------------------------------------------------------------------------
module line_char_arbiter #(
  parameter int PACE     = 4,
  parameter int LINE_MAX = 80,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] char_data,
  output logic       data_valid,
  output logic       grant_src,
  output logic       busy
);

  localparam int COL_W  = $clog2(LINE_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int PACE_W = (PACE > 1) ? $clog2(PACE) : 1;

  localparam logic [COL_W-1:0]  COL_LIMIT   = COL_W'(LINE_MAX);
  localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(TIMEOUT);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(PACE - 1);

  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [2:0] ST_IDLE     = 3'd0;
`ifdef LINE_TAG_EN
  localparam logic [2:0] ST_TAG_ID   = 3'd1;
  localparam logic [2:0] ST_TAG_SEP  = 3'd2;
  localparam logic [7:0] CHAR_COLON  = 8'h3A;
`endif
  localparam logic [2:0] ST_PASS     = 3'd3;
  localparam logic [2:0] ST_FORCE_NL = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [7:0]        char_q, char_d;
  logic              dv_q, dv_d;

  logic              paceZero;
  logic              passReady;
  logic              selValid;
  logic [7:0]        selData;
  logic              xfer;
  logic [COL_W-1:0]  colNext;
  logic [TO_W-1:0]   toNext;

  // Only the granted source is looked at; the other one simply sees ready
  // low, so its pending byte waits rather than being lost.
  assign selValid  = grant_q ? s1_valid : s0_valid;
  assign selData   = grant_q ? s1_data  : s0_data;
  assign paceZero  = (pace_q == '0);
  assign passReady = (state_q == ST_PASS) && paceZero;
  assign xfer      = passReady && selValid;

  assign s0_ready  = passReady && !grant_q;
  assign s1_ready  = passReady &&  grant_q;

  // Increments are computed once here so the compare against the limit uses
  // the value the counter is about to take.
  assign colNext = col_q + 1'b1;
  assign toNext  = (to_q == TO_LIMIT) ? to_q : to_q + 1'b1;

  assign char_data  = char_q;
  assign data_valid = dv_q;
  assign grant_src  = grant_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state logic. Every emission reloads the pace counter, and every
  // emitting state waits for it to reach zero first, so tag bytes and forced
  // newlines obey the same spacing as source bytes.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    col_d   = col_q;
    to_d    = to_q;
    char_d  = char_q;
    dv_d    = 1'b0;
    pace_d  = paceZero ? pace_q : pace_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          // On a tie the source that did not own the previous line wins.
          if (s0_valid && s1_valid) begin
            grant_d = ~last_q;
          end else begin
            grant_d = s1_valid;
          end
          col_d = '0;
          to_d  = '0;
`ifdef LINE_TAG_EN
          state_d = ST_TAG_ID;
`else
          state_d = ST_PASS;
`endif
        end
      end

`ifdef LINE_TAG_EN
      ST_TAG_ID: begin
        if (paceZero) begin
          char_d  = {7'b0011000, grant_q};
          dv_d    = 1'b1;
          pace_d  = PACE_RELOAD;
          col_d   = colNext;
          state_d = ST_TAG_SEP;
        end
      end

      ST_TAG_SEP: begin
        if (paceZero) begin
          char_d  = CHAR_COLON;
          dv_d    = 1'b1;
          pace_d  = PACE_RELOAD;
          col_d   = colNext;
          state_d = ST_PASS;
        end
      end
`endif

      ST_PASS: begin
        if (xfer) begin
          // A transfer always wins over a timeout landing in the same cycle.
          char_d = selData;
          dv_d   = 1'b1;
          pace_d = PACE_RELOAD;
          to_d   = '0;
          if (selData == CHAR_NL) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            col_d = colNext;
            if (colNext == COL_LIMIT) begin
              state_d = ST_FORCE_NL;
            end
          end
        end else if (!selValid) begin
          to_d = toNext;
          if (toNext == TO_LIMIT) begin
            state_d = ST_FORCE_NL;
          end
        end
      end

      ST_FORCE_NL: begin
        // Terminates the line on the source's behalf; nothing is consumed.
        if (paceZero) begin
          char_d  = CHAR_NL;
          dv_d    = 1'b1;
          pace_d  = PACE_RELOAD;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. last_q resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      col_q   <= '0;
      to_q    <= '0;
      pace_q  <= '0;
      char_q  <= CHAR_SPACE;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      col_q   <= col_d;
      to_q    <= to_d;
      pace_q  <= pace_d;
      char_q  <= char_d;
      dv_q    <= dv_d;
    end
  end

endmodule

// File: doc/line_char_arbiter.md
# line_char_arbiter

Shares the single character stream into `vga_display` (`char_data`/`data_valid`) between two byte-producing requesters, such as a traffic decoder and a status reporter. Grants are whole lines, so text from the two sources never interleaves within a display row. The block paces emission, forces line breaks at the display width, and reclaims a grant from a stalled source. It sits directly upstream of `vga_display`, and its outputs connect straight to that module's character inputs.

## Interface
- `PACE`, 4: minimum clocks between consecutive `data_valid` pulses (≥1).
- `LINE_MAX`, 80: maximum non-newline characters per line, including any tag.
- `TIMEOUT`, 1024: consecutive cycles the granted source may hold `valid` low before its line is terminated (≥2).
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `s0_data`, in, 8: source 0 byte.
- `s0_valid`, in, 1: source 0 byte available.
- `s0_ready`, out, 1: source 0 byte accepted this cycle when `s0_valid` is also high.
- `s1_data`, `s1_valid`, `s1_ready`: same as source 0, for source 1.
- `char_data`, out, 8: byte to display, registered.
- `data_valid`, out, 1: one-cycle strobe qualifying `char_data`, registered.
- `grant_src`, out, 1: index of the currently or last granted source.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States are IDLE, TAG_ID, TAG_SEP, PASS and FORCE_NL. The tag states exist only with `LINE_TAG_EN`.
- **IDLE:**
  - With neither valid high, the block stays in IDLE.
  - With one valid high, that source is granted.
  - With both valid high, the source not equal to `last_src` is granted (round-robin).
  - `grant_src` updates on the grant. The block moves to TAG_ID if tagging is enabled, otherwise to PASS.
  - Column and timeout counters clear on the grant.
- **TAG_ID:** emits `0x30 + grant_src`, then moves to TAG_SEP.
- **TAG_SEP:** emits `0x3A`, then moves to PASS. Each tag byte counts one column.
- **PASS:**
  - `sN_ready` for the granted source equals (state == PASS) && (pace counter == 0) && not forcing.
  - The ungranted source's ready is always 0.
  - On a transfer (valid && ready), the byte is emitted next cycle and the timeout counter clears.
  - If the accepted byte is `0x0A`: emit it, set `last_src <= grant_src`, go to IDLE.
  - Otherwise the column counter increments. If it reaches `LINE_MAX`, go to FORCE_NL.
  - Each cycle the granted source's valid is low, the timeout counter increments. When it reaches `TIMEOUT`, go to FORCE_NL.
- **FORCE_NL:** when the pace counter is 0, emit `0x0A`, set `last_src <= grant_src`, go to IDLE. No source byte is consumed.
- **Pacing:** every emission loads the pace counter with `PACE-1`. The counter decrements to 0 and gates all emissions, including tag bytes and forced newlines.
- **Widths:**
  - Column counter is `$clog2(LINE_MAX+1)` bits.
  - Timeout counter is `$clog2(TIMEOUT+1)` bits and saturates.
  - Pace counter is `$clog2(PACE)` bits, minimum 1.

## Timing
- Reset values:
  - `char_data = 0x20`, `data_valid = 0`, both readies 0, `grant_src = 0`, `busy = 0`.
  - State is IDLE, `last_src = 1` (source 0 wins the first tie), all counters 0.
- Grant latency is one cycle: a valid seen in IDLE produces ready, or the first tag emission, on the next cycle at the earliest.
- Accept-to-output latency is one cycle: the byte accepted at edge N appears on `char_data` with `data_valid = 1` during cycle N+1.
- `data_valid` is never high on two consecutive cycles when `PACE > 1`. With `PACE = 1`, back-to-back emissions are allowed.
- `char_data` holds its last value between strobes.
- The non-granted source's valid is ignored until the block returns to IDLE. It is never dropped, because its ready stays 0.
- A `0x0A` arriving exactly when the column counter would reach `LINE_MAX` is not possible, since newlines do not count. A newline accepted as the 80th byte after 79 characters ends the line normally, with no extra forced newline.
- If the timeout expires in the same cycle as a transfer, the transfer wins and the timeout counter clears.
- Reset mid-line returns all registers to their reset values on the next edge. No partial newline is emitted.

## Configuration
- `LINE_TAG_EN`:
  - Defined: TAG_ID and TAG_SEP exist. Each line is prefixed `"0:"` or `"1:"`, and the two tag bytes count toward `LINE_MAX`, leaving 78 data characters at default settings.
  - Undefined: the grant goes directly to PASS and no prefix is emitted.

## Test plan
- Reset, then s0 sends `"AB\n"` at `PACE = 4`, no tag: strobes carry `0x41`, `0x42`, `0x0A`, spaced 4 cycles apart. Afterwards `busy = 0` and `last_src = 0`.
- s0 and s1 both valid continuously after reset: the first line goes to s0, the next to s1, then s0 again. No byte from the ungranted source appears mid-line.
- s1 streams 85 non-newline bytes: after the 80th, a `0x0A` is forced and the grant is released. The remaining 5 bytes go out after re-arbitration.
- s0 granted, sends `"X"`, then holds valid low for 1024 cycles: `0x58` is emitted, followed by a forced `0x0A` after the timeout.
- `LINE_TAG_EN` defined, s1 sends `"Z\n"`: strobes carry `0x31`, `0x3A`, `0x5A`, `0x0A`.
- `rst` asserted while s0 is mid-line: the next cycle shows `data_valid = 0`, `char_data = 0x20` and both readies 0. A subsequent tie is granted to s0.
